// File: rtl/timebase_defs.sv
// Shared definitions for the programmable timebase: FSM state
// encodings and default port widths.
package timebase_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_PRESCALE_W = 8;
  localparam int DEF_COUNT_W    = 16;

endpackage

// File: rtl/timebase_tick_gen_prescaler.sv
// Loadable down-counter with a reload value and enable.
// Registered one-cycle pulse on each terminal (zero) count.
module tick_prescaler
  import timebase_defs::*;
#(
  parameter int W = DEF_PRESCALE_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] reload,
  output logic         fire,
  output logic         pulse
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pulse_q, pulse_d;

  always_comb begin
    fire    = en && (cnt_q == '0);
    cnt_d   = cnt_q;
    pulse_d = fire;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = fire ? reload : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/timebase_tick_gen.sv
// Programmable timebase: bursts of periodic one-cycle ticks.
// Build option TIMEBASE_TICK_GEN_AUTORELOAD_EN restarts bursts from DONE.
module timebase_tick_gen
  import timebase_defs::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int COUNT_W    = DEF_COUNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [COUNT_W-1:0]    burst_len,
  output logic                  tick,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_W-1:0]    tick_count
);

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   p_q, p_d;
  logic [COUNT_W-1:0]      l_q, l_d;
  logic [COUNT_W-1:0]      cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ld, en, fire, tick_pulse;
  logic [PRESCALE_W-1:0]   ld_val;
  logic                    term_seen;

  // Terminal tick was issued last cycle; no further ticks this burst.
  assign term_seen = tick_pulse && (l_q != '0) && (cnt_q == l_q);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ld_val  = p_q;
    en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          p_d     = prescale;
          l_d     = burst_len;
          cnt_d   = '0;
          ld      = 1'b1;
          ld_val  = prescale;
        end
      end
      ST_RUN: begin
        en = !term_seen;
        if (fire) cnt_d = cnt_q + COUNT_W'(1);
        if (stop) begin
          state_d = ST_IDLE;
        end else if (term_seen) begin
          state_d = ST_DONE;
          ld      = 1'b1;
        end
      end
      ST_DONE: begin
`ifdef TIMEBASE_TICK_GEN_AUTORELOAD_EN
        en      = 1'b1;
        state_d = ST_RUN;
        cnt_d   = COUNT_W'(fire);
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      l_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  tick_prescaler #(.W(PRESCALE_W)) u_presc (
    .clock    (clock),
    .reset    (reset),
    .load     (ld),
    .en       (en),
    .load_val (ld_val),
    .reload   (p_q),
    .fire     (fire),
    .pulse    (tick_pulse)
  );

  assign tick       = tick_pulse;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tick_count = cnt_q;

endmodule

// File: tb/tb_timebase_tick_gen.sv
// Bench for timebase_tick_gen: directed literal checks plus randomized
// stimulus against a per-edge arithmetic model, on 16-bit and 4-bit counts.
module tb_timebase_tick_gen;

`ifdef TIMEBASE_TICK_GEN_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  prescale;
  logic [15:0] burst_len;
  logic        tick16, busy16, done16;
  logic [15:0] cnt16;
  logic        tick4, busy4, done4;
  logic [3:0]  cnt4;

  int n_run;
  int n_fail;

  timebase_tick_gen #(.PRESCALE_W(8), .COUNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .prescale   (prescale),
    .burst_len  (burst_len),
    .tick       (tick16),
    .busy       (busy16),
    .done       (done16),
    .tick_count (cnt16)
  );

  timebase_tick_gen #(.PRESCALE_W(8), .COUNT_W(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .prescale   (prescale),
    .burst_len  (burst_len[3:0]),
    .tick       (tick4),
    .busy       (busy4),
    .done       (done4),
    .tick_count (cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // mode: 0 idle, 1 running, 2 done cycle. s = reference edge of period grid.
  typedef struct {
    int mode;
    int s;
    int p;
    int l;
    int cnt;
    bit tick;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, int e, bit rst, bit st, bit sp,
                                 int pre, int bl, int mask);
    mdl_t n;
    bit   fin;
    n = m;
    n.tick = 1'b0;
    if (rst) begin
      n.mode = 0; n.s = 0; n.p = 0; n.l = 0; n.cnt = 0;
      return n;
    end
    case (m.mode)
      0: begin
        if (st && !sp) begin
          n.mode = 1; n.s = e; n.p = pre; n.l = bl & mask; n.cnt = 0;
        end
      end
      1: begin
        fin = (m.l != 0) && (m.cnt == m.l);
        if (!fin) begin
          n.tick = ((e - m.s) % (m.p + 1)) == 0;
          if (n.tick) n.cnt = (m.cnt + 1) & mask;
        end
        if (sp) n.mode = 0;
        else if (fin) begin
          n.mode = 2; n.s = e;
        end
      end
      default: begin
        if (AR) begin
          n.mode = 1;
          n.tick = ((e - m.s) % (m.p + 1)) == 0;
          n.cnt  = n.tick ? 1 : 0;
        end else begin
          n.mode = 0;
        end
      end
    endcase
    return n;
  endfunction

  mdl_t m16 = '{0, 0, 0, 0, 0, 1'b0};
  mdl_t m4  = '{0, 0, 0, 0, 0, 1'b0};
  int   edge_no = 0;
  bit   armed = 1'b0;

  always @(posedge clock) begin
    edge_no++;
    if (reset) armed = 1'b1;
    m16 = mstep(m16, edge_no, reset, start, stop,
                int'(prescale), int'(burst_len), 32'hFFFF);
    m4  = mstep(m4, edge_no, reset, start, stop,
                int'(prescale), int'(burst_len), 32'hF);
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("m_tick16", tick16, m16.tick);
      chk("m_busy16", busy16, m16.mode != 0);
      chk("m_done16", done16, m16.mode == 2);
      chk("m_cnt16",  cnt16,  m16.cnt);
      chk("m_tick4",  tick4,  m4.tick);
      chk("m_busy4",  busy4,  m4.mode != 0);
      chk("m_done4",  done4,  m4.mode == 2);
      chk("m_cnt4",   cnt4,   m4.cnt);
    end
  end

  // Returns just after the accepting edge N; next negedge is cycle N.
  task automatic launch(input int p, input int l);
    @(posedge clock); #1;
    prescale  = 8'(p);
    burst_len = 16'(l);
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic quiesce();
    @(posedge clock); #1;
    stop = 1'b1;
    repeat (2) @(posedge clock);
    #1 stop = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    reset = 1'b1; start = 1'b1; stop = 1'b0;
    prescale = 8'd5; burst_len = 16'd7;

    // reset held 3 cycles with start asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_tick", tick16, 0);
      chk("rst_busy", busy16, 0);
      chk("rst_done", done16, 0);
      chk("rst_cnt",  cnt16,  0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    chk("rst_idle_busy", busy16, 0);

    // P=0, L=4
    launch(0, 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("t2_tick", tick16, (k >= 1 && k <= 4) || (AR && k >= 6));
      chk("t2_done", done16, k == 5);
      chk("t2_busy", busy16, (k <= 5) || AR);
      if (k <= 5) chk("t2_cnt", cnt16, (k <= 4) ? k : 4);
    end
    quiesce();

    // P=3, L=3, prescale changed mid-run
    launch(3, 3);
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (k == 2) prescale = 8'd9;
      chk("t3_tick", tick16, k == 4 || k == 8 || k == 12);
      chk("t3_done", done16, k == 13);
      if (k == 12) chk("t3_cnt", cnt16, 3);
      if (k == 14) chk("t3_busy", busy16, AR);
    end
    quiesce();

    // P=1 free-run, stop coincident with 5th tick
    launch(1, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("t4_tick", tick16, k > 0 && k <= 10 && (k % 2) == 0);
      chk("t4_done", done16, 0);
      if (k == 10) begin
        chk("t4_cnt10", cnt16, 5);
        stop = 1'b1;
      end
      if (k == 11) begin
        chk("t4_busy", busy16, 0);
        chk("t4_cnt11", cnt16, 5);
        stop = 1'b0;
      end
    end

    // start+stop together in IDLE; start while busy
    @(posedge clock); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clock);
    chk("t5_ss_busy", busy16, 0);
    chk("t5_ss_cnt", cnt16, 5);
    launch(2, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 7) begin
        start = 1'b1; prescale = 8'd0; burst_len = 16'd1;
      end
      if (k == 8) begin
        start = 1'b0;
        chk("t5_cnt8", cnt16, 2);
        chk("t5_busy8", busy16, 1);
      end
      if (k == 9) begin
        chk("t5_tick9", tick16, 1);
        chk("t5_cnt9", cnt16, 3);
      end
    end
    quiesce();

    // 4-bit wrap
    launch(0, 0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      if (k == 15) chk("t6_cnt4_15", cnt4, 15);
      if (k == 16) begin
        chk("t6_cnt4_wrap", cnt4, 0);
        chk("t6_tick4", tick4, 1);
        chk("t6_cnt16", cnt16, 16);
      end
    end
    quiesce();

    // L=2 bursts; repeat every 3 cycles with autoreload
    launch(0, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("t6_done", done16, k > 0 && (k % 3) == 0 && (AR || k == 3));
      if (k == 4) chk("t6_busy4", busy16, AR);
    end
    quiesce();

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 599) == 0);
      prescale = ($urandom_range(0, 9) == 0) ?
                 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
      burst_len = ($urandom_range(0, 9) == 0) ?
                  16'($urandom_range(14, 20)) : 16'($urandom_range(0, 5));
    end
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
